// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for multi-cycle ops: tracks in-flight destinations per register
// file and stalls ID instructions that read, overwrite or overflow an outstanding result.
module hazard_scoreboard #(
    parameter int REG_AW        = 5,
    parameter int FP_EN         = 1,
    parameter int MAX_PENDING   = 4,
    parameter int RELEASE_DELAY = 1,
    parameter int CNT_W         = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              iss_fp,
    input  logic              cpl_valid,
    input  logic [REG_AW-1:0] cpl_rd,
    input  logic              cpl_fp,
    input  logic              flush,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rs3,
    input  logic [2:0]        id_rs_fp,
    input  logic [2:0]        id_rs_use,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_fp,
    input  logic              id_rd_we,
    input  logic              id_is_multi,
    output logic              sb_stall,
    output logic              sb_full,
    output logic [CNT_W-1:0]  sb_count,
    output logic              sb_err
);
    localparam int NREG = 1 << REG_AW;
    // A delay of 0 or 1 both clear at the edge ending the completion cycle; each
    // further cycle of delay needs one register stage.
    localparam int NST = (RELEASE_DELAY > 1) ? RELEASE_DELAY - 1 : 0;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAXC  = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] MAXM1 = CNT_W'(MAX_PENDING - 1);

    logic [NREG-1:0]   pend_i_r, pend_f_r, pend_i_s, pend_f_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic              full_r, err_r, err_s;
    logic              exit_v_s, exit_fp_s;
    logic [REG_AW-1:0] exit_rd_s;
    logic              cpl_ok_s, iss_ok_s, iss_prev_s;
    logic              raw_s, waw_s, strct_s;

    assign cpl_ok_s   = cpl_valid & (~cpl_fp | (FP_EN != 0));
    assign iss_ok_s   = iss_valid & (iss_fp ? (FP_EN != 0) : (iss_rd != '0));
    assign iss_prev_s = iss_fp ? pend_f_r[iss_rd] : pend_i_r[iss_rd];

    generate
        if (NST == 0) begin : g_direct
            assign exit_v_s  = cpl_ok_s;
            assign exit_rd_s = cpl_rd;
            assign exit_fp_s = cpl_fp;
        end else begin : g_pipe
            logic [NST-1:0]    v_r, fp_r;
            logic [REG_AW-1:0] rd_r [NST];

            // Release delay line; flush and reset drop everything in flight.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v_r  <= '0;
                    fp_r <= '0;
                    for (int i = 0; i < NST; i++) rd_r[i] <= '0;
                end else if (flush) begin
                    v_r  <= '0;
                    fp_r <= '0;
                    for (int i = 0; i < NST; i++) rd_r[i] <= '0;
                end else begin
                    v_r[0]  <= cpl_ok_s;
                    rd_r[0] <= cpl_rd;
                    fp_r[0] <= cpl_fp;
                    for (int i = NST - 1; i > 0; i--) begin
                        v_r[i]  <= v_r[i-1];
                        rd_r[i] <= rd_r[i-1];
                        fp_r[i] <= fp_r[i-1];
                    end
                end
            end

            assign exit_v_s  = v_r[NST-1];
            assign exit_rd_s = rd_r[NST-1];
            assign exit_fp_s = fp_r[NST-1];
        end
    endgenerate

    function automatic logic eff(input logic [NREG-1:0] pi, input logic [NREG-1:0] pf,
                                 input logic iv, input logic ifp, input logic [REG_AW-1:0] ird,
                                 input logic fp, input logic [REG_AW-1:0] r);
        logic hit;
        hit = iv & (ifp == fp) & (ird == r);
        if (fp) begin
            eff = (FP_EN != 0) & (pf[r] | hit);
        end else if (r == '0) begin
            eff = 1'b0;
        end else begin
            eff = pi[r] | hit;
        end
    endfunction

    // Next state: release is applied before issue so a same-register pair leaves the bit set.
    always_comb begin
        pend_i_s = pend_i_r;
        pend_f_s = pend_f_r;
        count_s  = count_r;
        err_s    = err_r;
        if (flush) begin
            pend_i_s = '0;
            pend_f_s = '0;
            count_s  = '0;
        end else begin
            if (exit_v_s && exit_fp_s) begin
                if (pend_f_s[exit_rd_s]) begin
                    pend_f_s[exit_rd_s] = 1'b0;
                    count_s             = count_s - ONE;
                end else begin
                    err_s = 1'b1;
                end
            end else if (exit_v_s && (exit_rd_s != '0)) begin
                if (pend_i_s[exit_rd_s]) begin
                    pend_i_s[exit_rd_s] = 1'b0;
                    count_s             = count_s - ONE;
                end else begin
                    err_s = 1'b1;
                end
            end else begin
                count_s = count_r;
            end

            if (iss_ok_s && full_r && !iss_prev_s) begin
                err_s = 1'b1;
            end else if (iss_ok_s && iss_fp && !pend_f_s[iss_rd]) begin
                pend_f_s[iss_rd] = 1'b1;
                count_s          = count_s + ONE;
            end else if (iss_ok_s && !iss_fp && !pend_i_s[iss_rd]) begin
                pend_i_s[iss_rd] = 1'b1;
                count_s          = count_s + ONE;
            end else begin
                pend_i_s = pend_i_s;
            end
        end
    end

    // Scoreboard state and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_i_r <= '0;
            pend_f_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            pend_i_r <= pend_i_s;
            pend_f_r <= pend_f_s;
            count_r  <= count_s;
            full_r   <= (count_s == MAXC);
            err_r    <= err_s;
        end
    end

    // Hazard detection against registered state plus the same-cycle issue bypass.
    always_comb begin
        raw_s = (id_rs_use[0] & eff(pend_i_r, pend_f_r, iss_valid, iss_fp, iss_rd, id_rs_fp[0], id_rs1))
              | (id_rs_use[1] & eff(pend_i_r, pend_f_r, iss_valid, iss_fp, iss_rd, id_rs_fp[1], id_rs2))
              | (id_rs_use[2] & eff(pend_i_r, pend_f_r, iss_valid, iss_fp, iss_rd, id_rs_fp[2], id_rs3));
        waw_s   = id_rd_we & eff(pend_i_r, pend_f_r, iss_valid, iss_fp, iss_rd, id_rd_fp, id_rd);
        strct_s = id_is_multi & (full_r | (iss_valid & (count_r == MAXM1)));
    end

    assign sb_stall = (raw_s | waw_s | strct_s) & ~flush;
    assign sb_full  = full_r;
    assign sb_count = count_r;
    assign sb_err   = err_r;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised per-register pending-write scoreboard that replaces the purely combinational multi-cycle stall rules (M, A, FP multi-cycle ops) in the core's hazard logic. It tracks outstanding destination writes for integer and FP register files, stalls only instructions in ID that actually depend on or collide with an in-flight result, and holds each entry for a configurable number of cycles after completion. That hold covers the window before MEM→ID forwarding becomes valid, such as the atomic completion transition cycle. It sits beside the load-use/CSR hazard logic; its `sb_stall` is ORed into `stall_pc`/`stall_ifid`/`bubble_idex`.

## Interface
Parameters:
- `REG_AW`, 5, register index width; each file has 2^REG_AW entries.
- `FP_EN`, 1, instantiate the FP pending file. When 0, FP inputs are ignored and the FP file reads as all-zero.
- `MAX_PENDING`, 4, maximum simultaneously outstanding entries across both files (1..2^(REG_AW+1)).
- `RELEASE_DELAY`, 1, cycles (0..3) between `cpl_valid` and the entry clearing.
- `CNT_W`, `$clog2(MAX_PENDING+1)`, width of the pending counter.

Ports:
- `clk`, in, 1, core clock.
- `reset_n`, in, 1, asynchronous active-low reset.
- `iss_valid`, in, 1, multi-cycle op enters EX this cycle (first EX cycle only).
- `iss_rd`, in, REG_AW, its destination register.
- `iss_fp`, in, 1, destination is in the FP file.
- `cpl_valid`, in, 1, multi-cycle op result is written this cycle.
- `cpl_rd`, in, REG_AW, its destination register.
- `cpl_fp`, in, 1, destination is in the FP file.
- `flush`, in, 1, pipeline flush (trap, xRET, mispredict); discards all tracking.
- `id_rs1`, `id_rs2`, `id_rs3`, in, REG_AW each, ID source indices.
- `id_rs_fp`, in, 3, per-source file select (bit0=rs1, bit1=rs2, bit2=rs3).
- `id_rs_use`, in, 3, per-source valid.
- `id_rd`, in, REG_AW, ID destination index.
- `id_rd_fp`, in, 1, ID destination file select.
- `id_rd_we`, in, 1, ID instruction writes `id_rd`.
- `id_is_multi`, in, 1, ID instruction is a multi-cycle op.
- `sb_stall`, out, 1, stall the ID instruction.
- `sb_full`, out, 1, pending count equals MAX_PENDING.
- `sb_count`, out, CNT_W, number of outstanding entries.
- `sb_err`, out, 1, sticky protocol error.

## Operation
- State:
  - Int pending vector `pend_i[2^REG_AW]`.
  - FP pending vector `pend_f`.
  - Release shift pipeline of RELEASE_DELAY stages, each holding {valid, rd, fp}.
  - `count`.
  - Sticky `err`.
- Issue:
  - At the edge with `iss_valid`, set `pend[iss_fp][iss_rd]`.
  - Int index 0 is never set. If `iss_fp` and !FP_EN, the issue is ignored.
  - `count` increments only if the bit was previously clear.
- Completion:
  - `cpl_valid` pushes {cpl_rd, cpl_fp} into the release pipeline.
  - The entry clears when it exits after RELEASE_DELAY edges. With RELEASE_DELAY=0 it clears at the same edge as `cpl_valid`.
  - `count` decrements when the bit actually clears.
  - Completion of a register that is not pending at exit is ignored and sets `err`.
- Same register released and issued on the same edge: issue wins, bit stays set, `count` unchanged.
- Distinct release and issue on the same edge: count +1−1.
- `iss_valid` while `sb_full` and the target bit is clear: the issue is dropped and `err` is set.
- `flush` takes priority over everything:
  - Clears both vectors, the release pipeline and `count`.
  - Same-cycle `iss_valid`/`cpl_valid` are discarded.
  - `err` is kept.
- Hazard (combinational from registered state plus issue bypass):
  - Effective pending `eff(f,r) = pend[f][r] | (iss_valid & iss_fp==f & iss_rd==r)`, excluding int r=0.
  - `raw` = any used source s with `eff(id_rs_fp[s], id_rsN)`.
  - `waw` = `id_rd_we & eff(id_rd_fp, id_rd)`.
  - `struct` = `id_is_multi & (sb_full | (iss_valid & count==MAX_PENDING-1))`.
  - `sb_stall = (raw | waw | struct) & !flush`.

## Timing
- Reset (async, `reset_n` low): all vectors 0, pipeline empty, `count`=0, `err`=0, `sb_stall`=0, `sb_full`=0.
- Issue is visible to `sb_stall` the same cycle via the bypass, and from the register in the next cycle.
- `cpl_valid` in cycle N: the entry still stalls dependants through cycle N+RELEASE_DELAY−1 and is clear in cycle N+RELEASE_DELAY. For delay 0, it is clear in cycle N+1.
- `sb_count`, `sb_full` and `sb_err` are registered outputs. `sb_stall` is combinational.
- Reset asserted mid-operation discards all in-flight entries immediately, including in-flight release stages.

## Test plan
- RELEASE_DELAY=1: issue int rd=5 (cycle 0), ID rs1=5 → `sb_stall`=1 in cycles 0..k. `cpl_valid` rd=5 in cycle 4 → stall still 1 in cycle 4, 0 in cycle 5. `sb_count` goes 0→1→0.
- Issue int rd=0 → no stall on rs1=0, `sb_count` stays 0. Issue FP f0, ID FP rs3=0 with `id_rs_use`[2]=1 → stall. Same test with FP_EN=0 → no stall.
- MAX_PENDING=4: issue rd 1,2,3,4 → `sb_full`=1, ID `id_is_multi` stalls. A 5th issue (rd=6) → dropped, `err`=1, `count`=4.
- Release rd=7 and issue rd=7 on the same edge → bit remains 1, `count` unchanged. Release rd=9 that was never issued → `err`=1.
- Issue rd 3 and FP 8, then `flush` together with `iss_valid` rd=10 → all clear, `count`=0, no stall on 3/8/10 next cycle.
- Assert `reset_n`=0 asynchronously with 2 entries pending and one in the release pipeline → outputs 0 immediately. After release, completion of rd 3 → ignored, `err`=1.
